screen_ctrl: RTL and testbench

- Top-level screen sequencer that drives the `screen` select of the VGA screen selector path: START menu, GAME, and the PLAYER_1 / PLAYER_2 winner screens.
- Debounces the start button and latches win events from game logic.
- Commits every screen change only at the start of vertical blanking, so no frame is drawn with mixed screens.
- Issues a one-cycle reset pulse to game logic whenever a new game begins.

---
 rtl/screen_ctrl_if.sv | 33 +++
 rtl/screen_ctrl.sv | 164 ++++++++++++++++
 tb/tb_screen_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/screen_ctrl_if.sv
// Screen select encoding shared with the VGA screen selector path, and the
// signal bundle between the screen sequencer and the rest of the VGA top.
// The sequencer connects to the slave modport. The surrounding logic (or a
// bench) connects to the master modport.

package vga_pkg;
   typedef enum logic [1:0] {
      START    = 2'd0,
      GAME     = 2'd1,
      PLAYER_1 = 2'd2,
      PLAYER_2 = 2'd3
   } screen_t;
endpackage

interface screen_ctrl_if;
   logic             vblnk;
   logic             btn_start;
   logic             p1_win;
   logic             p2_win;
   vga_pkg::screen_t screen;
   logic             game_rst;
   logic             frame_tick;

   modport master (
      output vblnk, btn_start, p1_win, p2_win,
      input  screen, game_rst, frame_tick
   );

   modport slave (
      input  vblnk, btn_start, p1_win, p2_win,
      output screen, game_rst, frame_tick
   );
endinterface

// File: rtl/screen_ctrl.sv
// Screen sequencer: START menu -> GAME -> PLAYER_1 / PLAYER_2 winner screen.
// The start button is synchronised and debounced. Win pulses are latched.
// Every screen change is committed only on the frame tick (rising vblnk), so
// a frame is never drawn with mixed screens.
// Optional build macro AUTO_RETURN_EN: a winner screen returns to START by
// itself once it has been shown for WIN_HOLD_FRAMES frames.

module screen_ctrl #(
   parameter int DEBOUNCE_CYCLES = 65000,
   parameter int MIN_HOLD_FRAMES = 60,
   parameter int WIN_HOLD_FRAMES = 300,
   parameter int CNT_W           = 16
) (
   input  logic         clk,
   input  logic         rst,
   screen_ctrl_if.slave bus
);
   import vga_pkg::*;

   localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] MIN_HOLD = CNT_W'(MIN_HOLD_FRAMES);
`ifdef AUTO_RETURN_EN
   localparam logic [CNT_W-1:0] WIN_HOLD = CNT_W'(WIN_HOLD_FRAMES);
`endif

   if (WIN_HOLD_FRAMES < MIN_HOLD_FRAMES) begin : g_bad_hold
      $error("screen_ctrl: WIN_HOLD_FRAMES must be >= MIN_HOLD_FRAMES");
   end

   logic             btn_s1;
   logic             btn_s2;
   logic [CNT_W-1:0] db_cnt;
   logic             btn_db;
   logic             press;
   logic             vblnk_d;
   logic             frame_tick;
   screen_t          screen;
   logic             game_rst;
   logic             start_req;
   logic             win_req;
   screen_t          win_id;
   logic [CNT_W-1:0] frame_cnt;
   logic             on_winner;

   assign on_winner = (screen == PLAYER_1) || (screen == PLAYER_2);

   // Two-flop synchroniser for the asynchronous button input.
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_s1 <= 1'b0;
         btn_s2 <= 1'b0;
      end else begin
         btn_s1 <= bus.btn_start;
         btn_s2 <= btn_s1;
      end
   end

   // Debounce: the counter runs only while the synced level differs from
   // the accepted level. Any return to the accepted level restarts it, so
   // only a level that stays stable long enough is accepted. A press is the
   // accepted 0->1 transition and lasts one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         db_cnt <= '0;
         btn_db <= 1'b0;
         press  <= 1'b0;
      end else begin
         press <= 1'b0;
         if (btn_s2 == btn_db) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            db_cnt <= '0;
            btn_db <= btn_s2;
            press  <= btn_s2;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   // Frame tick: registered rising-edge detect of vblnk.
   always_ff @(posedge clk) begin
      if (rst) begin
         vblnk_d    <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         vblnk_d    <= bus.vblnk;
         frame_tick <= bus.vblnk & ~vblnk_d;
      end
   end

   // Screen FSM. Requests are latched in any cycle, and transitions are
   // committed on the frame tick. The commit is written after the request
   // latching, so a request consumed in this cycle is cleared even if a new
   // press arrives in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         screen    <= START;
         game_rst  <= 1'b0;
         start_req <= 1'b0;
         win_req   <= 1'b0;
         win_id    <= PLAYER_1;
         frame_cnt <= '0;
      end else begin
         game_rst <= 1'b0;

         if (press && ((screen == START) || (on_winner && (frame_cnt >= MIN_HOLD)))) begin
            start_req <= 1'b1;
         end

         if ((screen == GAME) && !win_req && (bus.p1_win || bus.p2_win)) begin
            win_req <= 1'b1;
            win_id  <= bus.p1_win ? PLAYER_1 : PLAYER_2;
         end

         case (screen)
            START: begin
               if (frame_tick && start_req) begin
                  screen    <= GAME;
                  game_rst  <= 1'b1;
                  start_req <= 1'b0;
                  frame_cnt <= '0;
               end
            end
            GAME: begin
               if (frame_tick && win_req) begin
                  screen    <= win_id;
                  win_req   <= 1'b0;
                  frame_cnt <= '0;
               end
            end
            PLAYER_1, PLAYER_2: begin
               if (frame_tick) begin
                  if (start_req) begin
                     screen    <= START;
                     start_req <= 1'b0;
                     frame_cnt <= '0;
                  end
`ifdef AUTO_RETURN_EN
                  else if (frame_cnt == WIN_HOLD) begin
                     screen    <= START;
                     frame_cnt <= '0;
                  end
`endif
                  else if (frame_cnt != '1) begin
                     frame_cnt <= frame_cnt + 1'b1;
                  end
               end
            end
            default: begin
               screen    <= START;
               start_req <= 1'b0;
               win_req   <= 1'b0;
               frame_cnt <= '0;
            end
         endcase
      end
   end

   assign bus.screen     = screen;
   assign bus.game_rst   = game_rst;
   assign bus.frame_tick = frame_tick;

endmodule

// File: tb/tb_screen_ctrl.sv
// Bench for screen_ctrl. Inputs are driven frame by frame. A frame-level
// model of the screen rules predicts the screen and game_rst after every
// frame tick. Each prediction is queued and then checked by an independent
// monitor, which also checks that the screen never moves between ticks and
// that game_rst never fires outside a commit.

`timescale 1ns/1ps

module tb_screen_ctrl;
   import vga_pkg::*;

   localparam int DEBOUNCE_CYCLES = 8;
   localparam int MIN_HOLD_FRAMES = 4;
   localparam int WIN_HOLD_FRAMES = 6;
   localparam int CNT_W           = 16;
   localparam int ACTIVE          = 100;
   localparam int BLANK           = 10;
`ifdef AUTO_RETURN_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   typedef struct packed {
      screen_t scr;
      logic    gr;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   compared = 0;
   int   mismatched = 0;
   exp_t exp_q[$];

   screen_ctrl_if bus();

   screen_ctrl #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .MIN_HOLD_FRAMES(MIN_HOLD_FRAMES),
      .WIN_HOLD_FRAMES(WIN_HOLD_FRAMES),
      .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      compared++;
      if (act !== expv) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
      end
   endtask

   // Reference model, one step per frame.
   screen_t m_scr;
   bit      m_start_req;
   bit      m_win_req;
   screen_t m_win_id;
   int      m_fcnt;

   task automatic m_reset();
      m_scr       = START;
      m_start_req = 0;
      m_win_req   = 0;
      m_win_id    = PLAYER_1;
      m_fcnt      = 0;
   endtask

   task automatic m_press();
      if (m_scr == START ||
          ((m_scr == PLAYER_1 || m_scr == PLAYER_2) && m_fcnt >= MIN_HOLD_FRAMES))
         m_start_req = 1;
   endtask

   task automatic m_win(input screen_t w);
      if (m_scr == GAME && !m_win_req) begin
         m_win_req = 1;
         m_win_id  = w;
      end
   endtask

   task automatic m_tick();
      exp_t e;
      e.gr = 1'b0;
      if (m_scr == START) begin
         if (m_start_req) begin
            m_scr = GAME; m_start_req = 0; m_fcnt = 0; e.gr = 1'b1;
         end
      end else if (m_scr == GAME) begin
         if (m_win_req) begin
            m_scr = m_win_id; m_win_req = 0; m_fcnt = 0;
         end
      end else begin
         if (m_start_req) begin
            m_scr = START; m_start_req = 0; m_fcnt = 0;
         end else if (AUTO && m_fcnt == WIN_HOLD_FRAMES) begin
            m_scr = START; m_fcnt = 0;
         end else if (m_fcnt < (1 << CNT_W) - 1) begin
            m_fcnt++;
         end
      end
      e.scr = m_scr;
      exp_q.push_back(e);
   endtask

   // Monitor: runs on the opposite clock edge to the stimulus.
   screen_t last_scr = START;
   bit      tick_prev = 0;
   exp_t    mon_e;

   always @(negedge clk) begin
      if (rst) begin
         last_scr  = START;
         tick_prev = 0;
      end else begin
         if (tick_prev) begin
            if (exp_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_tick: got a frame tick, expected none at %0t", $time);
            end else begin
               mon_e = exp_q.pop_front();
               chk("screen_after_tick", 32'(bus.screen), 32'(mon_e.scr));
               chk("game_rst_after_tick", 32'(bus.game_rst), 32'(mon_e.gr));
               last_scr = mon_e.scr;
            end
         end else begin
            chk("screen_hold", 32'(bus.screen), 32'(last_scr));
            if (bus.game_rst !== 1'b0) chk("game_rst_stray", 32'(bus.game_rst), 32'd0);
         end
         if (bus.frame_tick && tick_prev) chk("frame_tick_width", 32'd2, 32'd1);
         tick_prev = bus.frame_tick;
      end
   end

   // One frame: ACTIVE cycles with vblnk low, then BLANK cycles with vblnk high.
   // win_kind: 0 none, 1 p1, 2 p2, 3 p1 and p2 together.
   task automatic run_frame(input bit do_press, input int bounces, input int win_kind,
                            input bit win2, input bit do_rst);
      int press_start = 5;
      int hi_start    = press_start + bounces * 6;
      int hi_end      = hi_start + 20;
      for (int c = 0; c < ACTIVE + BLANK; c++) begin
         @(posedge clk); #1;
         bus.vblnk     = (c >= ACTIVE);
         bus.btn_start = 1'b0;
         if (do_press) begin
            if (c >= press_start && c < hi_start)
               bus.btn_start = (((c - press_start) % 6) < 3);
            else if (c >= hi_start && c < hi_end)
               bus.btn_start = 1'b1;
         end
         bus.p1_win = (c == 75) && (win_kind == 1 || win_kind == 3);
         bus.p2_win = ((c == 75) && (win_kind == 2 || win_kind == 3)) || ((c == 85) && win2);
         rst        = do_rst && (c == 90);
         if (c == 95) begin
            if (do_press) m_press();
            if (win_kind != 0) m_win((win_kind == 2) ? PLAYER_2 : PLAYER_1);
            if (win2) m_win(PLAYER_2);
            if (do_rst) m_reset();
         end
         if (c == ACTIVE) m_tick();
      end
   endtask

   initial begin
      bus.vblnk     = 1'b0;
      bus.btn_start = 1'b0;
      bus.p1_win    = 1'b0;
      bus.p2_win    = 1'b0;
      rst           = 1'b1;
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_screen", 32'(bus.screen), 32'(START));
      chk("reset_game_rst", 32'(bus.game_rst), 32'd0);
      chk("reset_frame_tick", 32'(bus.frame_tick), 32'd0);
      rst = 1'b0;

      repeat (3) run_frame(0, 0, 0, 0, 0);      // idle in START
      run_frame(1, 5, 0, 0, 0);                 // bouncy press -> GAME
      run_frame(0, 0, 3, 1, 0);                 // p1+p2 together, later p2 -> PLAYER_1
      repeat (2) run_frame(0, 0, 0, 0, 0);
      run_frame(1, 0, 0, 0, 0);                 // press too early, ignored
      repeat (2) run_frame(0, 0, 0, 0, 0);
      run_frame(1, 1, 0, 0, 0);                 // qualified press -> START
      run_frame(1, 2, 0, 0, 0);                 // -> GAME
      run_frame(0, 0, 2, 0, 0);                 // -> PLAYER_2
      repeat (20) run_frame(0, 0, 0, 0, 0);     // hold, or auto return
      for (int i = 0; i < 3 && m_scr != GAME; i++) run_frame(1, 2, 0, 0, 0);
      run_frame(0, 0, 1, 0, 1);                 // win pending, then reset mid-frame
      run_frame(0, 0, 0, 0, 0);

      for (int i = 0; i < 40; i++) begin
         run_frame(($urandom_range(0, 2) == 0), $urandom_range(0, 5),
                   (($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0));
      end

      repeat (5) @(posedge clk);
      #1;
      chk("pending_expectations", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
